// File: rtl/merge_sorter_run_reader.sv
// Purpose: streams one merge pass out of the sort buffer, merging adjacent sorted runs of length R.
// Latency: first out_valid 6 cycles after start; then 3 cycles per element (EMIT, FETCH, CAPT).
// Backpressure: out_data/out_valid/out_last hold while out_ready is low; no reads are issued while stalled.
//
// Ports: clock/reset (async, active-low); start, data_length (N), run_length (R) begin a pass;
//        mem_rd/mem_addr/mem_data form a registered read port (data one cycle after mem_rd);
//        out_data/out_valid/out_ready/out_last carry the merged stream; busy spans the pass, done pulses at its end.
// Option: define MERGE_READER_DESCENDING_EN for a descending merge (ties still go to run A).
module merge_sorter_run_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_SORT_LENGTH = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [$clog2(MAX_SORT_LENGTH)-1:0] data_length,
  input  logic [$clog2(MAX_SORT_LENGTH):0]   run_length,
  output logic                               mem_rd,
  output logic [$clog2(MAX_SORT_LENGTH)-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]              mem_data,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);
  localparam int AW = $clog2(MAX_SORT_LENGTH);
  localparam logic [AW:0]   ONE_P = 1;
  localparam logic [AW-1:0] ONE_N = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH_A, S_CAPT_A, S_FETCH_B, S_CAPT_B, S_EMIT, S_FIN
  } state_t;

  state_t                state;
  logic [AW-1:0]         n_len;
  logic [AW:0]           r_len;
  logic [AW:0]           base, ia, ib, end_a, end_b;
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic                  a_v, b_v;
  logic                  refill_side;
  logic                  sel_a_q;
  logic [AW-1:0]         out_cnt;

  // Run bounds are summed one bit wider so that base+2R cannot wrap before the min with N.
  logic [AW+1:0] n_wide, sum_a, sum_b;
  logic [AW:0]   bnd_a, bnd_b;
  assign n_wide = {2'b00, n_len};
  assign sum_a  = {1'b0, base} + {1'b0, r_len};
  assign sum_b  = sum_a + {1'b0, r_len};
  assign bnd_a  = (sum_a < n_wide) ? sum_a[AW:0] : n_wide[AW:0];
  assign bnd_b  = (sum_b < n_wide) ? sum_b[AW:0] : n_wide[AW:0];

  logic [AW:0] ia_nx, ib_nx;
  logic        rd_a_nx, rd_b_nx;
  logic        cap_a, cap_b;
  assign ia_nx   = ia + ONE_P;
  assign ib_nx   = ib + ONE_P;
  assign rd_a_nx = ia_nx < end_a;
  assign rd_b_nx = ib_nx < end_b;
  // Pointers do not move between FETCH and CAPT, so the same compare tells CAPT whether a read was issued.
  assign cap_a   = ia < end_a;
  assign cap_b   = ib < end_b;

  // Head/flag values as they will be after this cycle's capture; the output register is loaded from
  // these on entry to EMIT so that out_* are registered yet valid in the first EMIT cycle.
  logic                  nav, nbv;
  logic [DATA_WIDTH-1:0] nha, nhb;
  always_comb begin
    nav = a_v;
    nha = head_a;
    nbv = b_v;
    nhb = head_b;
    if (state == S_CAPT_A) begin
      nav = cap_a;
      if (cap_a) nha = mem_data;
    end
    if (state == S_CAPT_B) begin
      nbv = cap_b;
      if (cap_b) nhb = mem_data;
    end
  end

  logic sel_a;
`ifdef MERGE_READER_DESCENDING_EN
  assign sel_a = nav & (~nbv | (nha >= nhb));
`else
  assign sel_a = nav & (~nbv | (nha <= nhb));
`endif

  logic emit_last;
  assign emit_last = (out_cnt == (n_len - ONE_N));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      n_len       <= '0;
      r_len       <= '0;
      base        <= '0;
      ia          <= '0;
      ib          <= '0;
      end_a       <= '0;
      end_b       <= '0;
      head_a      <= '0;
      head_b      <= '0;
      a_v         <= 1'b0;
      b_v         <= 1'b0;
      refill_side <= 1'b0;
      sel_a_q     <= 1'b0;
      out_cnt     <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_len   <= data_length;
            r_len   <= run_length;
            base    <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          end_a       <= bnd_a;
          end_b       <= bnd_b;
          ia          <= base;
          ib          <= bnd_a;
          refill_side <= 1'b0;
          mem_rd      <= base < bnd_a;
          if (base < bnd_a) mem_addr <= base[AW-1:0];
          state       <= S_FETCH_A;
        end
        S_FETCH_A: begin
          mem_rd <= 1'b0;
          state  <= S_CAPT_A;
        end
        S_FETCH_B: begin
          mem_rd <= 1'b0;
          state  <= S_CAPT_B;
        end
        S_CAPT_A, S_CAPT_B: begin
          a_v    <= nav;
          head_a <= nha;
          b_v    <= nbv;
          head_b <= nhb;
          if (state == S_CAPT_A && !refill_side) begin
            // Initial fill of a run pair: fetch the B head next.
            mem_rd <= cap_b;
            if (cap_b) mem_addr <= ib[AW-1:0];
            state  <= S_FETCH_B;
          end else begin
            sel_a_q   <= sel_a;
            out_valid <= nav | nbv;
            out_data  <= sel_a ? nha : nhb;
            out_last  <= (nav | nbv) & emit_last;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!a_v && !b_v) begin
            // Run pair exhausted: advance to the next pair or finish the pass.
            base <= sum_b[AW:0];
            if (sum_b >= n_wide) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              state <= S_SETUP;
            end
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_cnt     <= out_cnt + ONE_N;
            refill_side <= 1'b1;
            if (sel_a_q) begin
              ia     <= ia_nx;
              mem_rd <= rd_a_nx;
              if (rd_a_nx) mem_addr <= ia_nx[AW-1:0];
              state  <= S_FETCH_A;
            end else begin
              ib     <= ib_nx;
              mem_rd <= rd_b_nx;
              if (rd_b_nx) mem_addr <= ib_nx[AW-1:0];
              state  <= S_FETCH_B;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
